// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point FFT/IFFT stream blocks.
// Holds default width, output rounding constants and frame states.
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RND        = 2;
    localparam int SHIFT      = 2;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_e;

    // Clamp a signed value into a w-bit two's-complement range.
    function automatic int saturate(input int v, input int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ifft_4_point_stream_if.sv
// Sample stream bundle for the 4-point IFFT: input and output
// ready/valid channels plus output index and frame-last marker.
interface ifft_4_point_stream_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [1:0]               out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

endinterface

// File: rtl/ifft4_dit_core.sv
// Combinational radix-2 DIT 4-point inverse butterfly.
// Inputs in bit-reversed order (X0,X2,X1,X3), outputs natural x0..x3.
module ifft4_dit_core #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] x_re [4],
    input  logic signed [DATA_W-1:0] x_im [4],
    output logic signed [DATA_W+1:0] y_re [4],
    output logic signed [DATA_W+1:0] y_im [4]
);

    localparam int W2 = DATA_W + 2;

    logic signed [W2-1:0] e_re [4];
    logic signed [W2-1:0] e_im [4];
    logic signed [W2-1:0] p0_re, p0_im, p1_re, p1_im;
    logic signed [W2-1:0] q0_re, q0_im, q1_re, q1_im;

    // Sign-extend to the full internal width before any add
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            e_re[i] = W2'(x_re[i]);
            e_im[i] = W2'(x_im[i]);
        end
    end

    assign p0_re = e_re[0] + e_re[1];
    assign p0_im = e_im[0] + e_im[1];
    assign p1_re = e_re[0] - e_re[1];
    assign p1_im = e_im[0] - e_im[1];
    assign q0_re = e_re[2] + e_re[3];
    assign q0_im = e_im[2] + e_im[3];
    assign q1_re = e_re[2] - e_re[3];
    assign q1_im = e_im[2] - e_im[3];

    // Second stage: twiddle +j for the inverse transform
    assign y_re[0] = p0_re + q0_re;
    assign y_im[0] = p0_im + q0_im;
    assign y_re[1] = p1_re - q1_im;
    assign y_im[1] = p1_im + q1_re;
    assign y_re[2] = p0_re - q0_re;
    assign y_im[2] = p0_im - q0_im;
    assign y_re[3] = p1_re + q1_im;
    assign y_im[3] = p1_im - q1_re;

endmodule

// File: rtl/ifft_4_point_stream.sv
// Streaming 4-point IFFT: load 4 bit-reversed samples, compute in one
// cycle, unload 4 natural-order samples with ready/valid on both sides.
module ifft_4_point_stream
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter bit SCALE  = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    ifft_4_point_stream_if.slave bus
);

    localparam int W2 = DATA_W + 2;

    localparam logic [1:0] S_LOAD    = LOAD;
    localparam logic [1:0] S_COMPUTE = COMPUTE;
    localparam logic [1:0] S_UNLOAD  = UNLOAD;

    logic [1:0] state;
    logic [1:0] cnt;
    logic [1:0] idx;
    logic       load_hs;

    logic signed [DATA_W-1:0] sb_re  [4];
    logic signed [DATA_W-1:0] sb_im  [4];
    logic signed [DATA_W-1:0] res_re [4];
    logic signed [DATA_W-1:0] res_im [4];
    logic signed [W2-1:0]     y_re   [4];
    logic signed [W2-1:0]     y_im   [4];

    ifft4_dit_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .x_re(sb_re),
        .x_im(sb_im),
        .y_re(y_re),
        .y_im(y_im)
    );

    // Divide by 4 with round-half-up, or saturate when unscaled
    function automatic logic signed [DATA_W-1:0] fmt(
        input logic signed [W2-1:0] v
    );
        logic signed [W2-1:0] t;
        t = (v + W2'(RND)) >>> SHIFT;
        if (SCALE) return DATA_W'(t);
        return DATA_W'(saturate(int'(v), DATA_W));
    endfunction

    assign load_hs = (state == S_LOAD) && bus.in_valid;

    // Capture each accepted input sample into the frame buffer
    always_ff @(posedge clk) begin
        if (load_hs) begin
            sb_re[cnt] <= bus.in_re;
            sb_im[cnt] <= bus.in_im;
        end
    end

    // Frame sequencing, load/unload counters and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
            cnt   <= 2'd0;
            idx   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                res_re[i] <= '0;
                res_im[i] <= '0;
            end
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    for (int i = 0; i < 4; i++) begin
                        res_re[i] <= fmt(y_re[i]);
                        res_im[i] <= fmt(y_im[i]);
                    end
                    state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (bus.out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.out_valid = (state == S_UNLOAD);
    assign bus.out_re    = res_re[idx];
    assign bus.out_im    = res_im[idx];
    assign bus.out_idx   = idx;
    assign bus.out_last  = (state == S_UNLOAD) && (idx == 2'd3);

endmodule

// File: tb/tb_ifft_4_point_stream.sv
// Self-checking bench for ifft_4_point_stream: two instances in
// lockstep (scaled and unscaled) fed identical directed/random frames.
module tb_ifft_4_point_stream;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ifft_4_point_stream_if #(.DATA_W(16)) bus1 ();
    ifft_4_point_stream_if #(.DATA_W(16)) bus0 ();

    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.in_re     = bus1.in_re;
    assign bus0.in_im     = bus1.in_im;
    assign bus0.out_ready = bus1.out_ready;

    ifft_4_point_stream #(.DATA_W(16), .SCALE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    ifft_4_point_stream #(.DATA_W(16), .SCALE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] g1_re [4];
    logic signed [15:0] g1_im [4];
    logic signed [15:0] g0_re [4];
    logic signed [15:0] g0_im [4];
    logic [1:0]         gi [4];
    logic               gl [4];

    int vin_re [4];
    int vin_im [4];
    int x1_re [4];
    int x1_im [4];
    int x0_re [4];
    int x0_im [4];

    task automatic push(input int re, input int im);
        int t;
        t = 0;
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_re = 16'(re);
        bus1.in_im = 16'(im);
        while (bus1.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%b, need 1", bus1.in_ready);
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic pop(input int k);
        int t;
        t = 0;
        @(negedge clk);
        bus1.out_ready = 1'b1;
        while (bus1.out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL pop_timeout %0d: out_valid=%b, need 1", k, bus1.out_valid);
        end
        g1_re[k] = bus1.out_re;
        g1_im[k] = bus1.out_im;
        g0_re[k] = bus0.out_re;
        g0_im[k] = bus0.out_im;
        gi[k] = bus1.out_idx;
        gl[k] = bus1.out_last;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
    endtask

    task automatic run_vector(input string name);
        for (int k = 0; k < 4; k++) push(vin_re[k], vin_im[k]);
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s compute_cycle: valid=%b ready=%b, need 0 0",
                     name, bus1.out_valid, bus1.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus1.out_valid !== 1'b1 || bus0.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid=%b/%b, need 1/1",
                     name, bus1.out_valid, bus0.out_valid);
        end
        for (int k = 0; k < 4; k++) pop(k);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g1_re[k] !== 16'(x1_re[k]) || g1_im[k] !== 16'(x1_im[k]) ||
                gi[k] !== 2'(k) || gl[k] !== (k == 3)) begin
                errors++;
                $display("FAIL %s scaled n=%0d: got (%0d,%0d) idx %0d last %b, need (%0d,%0d) idx %0d last %b",
                         name, k, g1_re[k], g1_im[k], gi[k], gl[k],
                         x1_re[k], x1_im[k], k, (k == 3));
            end
            checks++;
            if (g0_re[k] !== 16'(x0_re[k]) || g0_im[k] !== 16'(x0_im[k])) begin
                errors++;
                $display("FAIL %s unscaled n=%0d: got (%0d,%0d), need (%0d,%0d)",
                         name, k, g0_re[k], g0_im[k], x0_re[k], x0_im[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.in_re = '0;
        bus1.in_im = '0;
        bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_idx, bus1.out_last,
             bus1.out_re, bus1.out_im} !== {1'b1, 1'b0, 2'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: rdy %b vld %b idx %0d last %b re %0d im %0d, need 1 0 0 0 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.out_idx,
                     bus1.out_last, bus1.out_re, bus1.out_im);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_trip();
        vin_re = '{10, -2, -2, -2};
        vin_im = '{0, 0, 2, -2};
        x1_re = '{1, 2, 3, 4};
        x1_im = '{0, 0, 0, 0};
        x0_re = '{4, 8, 12, 16};
        x0_im = '{0, 0, 0, 0};
        run_vector("round_trip");
    endtask

    task automatic test_impulse();
        vin_re = '{4, 4, 4, 4};
        vin_im = '{0, 0, 0, 0};
        x1_re = '{4, 0, 0, 0};
        x1_im = '{0, 0, 0, 0};
        x0_re = '{16, 0, 0, 0};
        x0_im = '{0, 0, 0, 0};
        run_vector("impulse");
    endtask

    task automatic test_saturation();
        vin_re = '{32767, 32767, 32767, 32767};
        vin_im = '{0, 0, 0, 0};
        x1_re = '{32767, 0, 0, 0};
        x1_im = '{0, 0, 0, 0};
        x0_re = '{32767, 0, 0, 0};
        x0_im = '{0, 0, 0, 0};
        run_vector("max_pos");
        vin_re = '{-32768, -32768, -32768, -32768};
        x1_re = '{-32768, 0, 0, 0};
        x0_re = '{-32768, 0, 0, 0};
        run_vector("max_neg");
        vin_re = '{0, 0, 1, 0};
        x1_re = '{0, 0, 0, 0};
        x0_re = '{1, 0, -1, 0};
        x0_im = '{0, 1, 0, -1};
        run_vector("round_x1");
    endtask

    task automatic test_backpressure();
        logic signed [15:0] r_re;
        logic signed [15:0] r_im;
        for (int k = 0; k < 4; k++) push(10 - ((k > 0) ? 12 : 0),
                                         (k == 2) ? 2 : ((k == 3) ? -2 : 0));
        bus1.in_valid = 1'b1;
        bus1.in_re = 16'sd7;
        bus1.in_im = 16'sd0;
        pop(0);
        @(negedge clk);
        r_re = bus1.out_re;
        r_im = bus1.out_im;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({bus1.out_valid, bus1.in_ready, bus1.out_idx, bus1.out_re, bus1.out_im} !==
                {1'b1, 1'b0, 2'd1, r_re, r_im} || r_re !== 16'sd2) begin
                errors++;
                $display("FAIL stall c=%0d: vld %b rdy %b idx %0d re %0d im %0d, need 1 0 1 2 0",
                         c, bus1.out_valid, bus1.in_ready, bus1.out_idx,
                         bus1.out_re, bus1.out_im);
            end
        end
        for (int k = 1; k < 4; k++) begin
            pop(k);
            checks++;
            if (g1_re[k] !== 16'(k + 1) || g0_re[k] !== 16'(4 * (k + 1)) ||
                bus1.in_ready !== (k == 3)) begin
                errors++;
                $display("FAIL stall_unload n=%0d: got %0d/%0d rdy %b, need %0d/%0d rdy %b",
                         k, g1_re[k], g0_re[k], bus1.in_ready,
                         k + 1, 4 * (k + 1), (k == 3));
            end
        end
        vin_re = '{7, 7, 7, 7};
        vin_im = '{0, 0, 0, 0};
        x1_re = '{7, 0, 0, 0};
        x1_im = '{0, 0, 0, 0};
        x0_re = '{28, 0, 0, 0};
        x0_im = '{0, 0, 0, 0};
        run_vector("after_stall");
    endtask

    task automatic test_reset_mid();
        push(100, 5);
        push(-50, 3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_idx} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_load: rdy %b vld %b idx %0d, need 1 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.out_idx);
        end
        test_round_trip();
        for (int k = 0; k < 4; k++) push(4, 0);
        pop(0);
        pop(1);
        @(negedge clk);
        checks++;
        if (bus1.out_idx !== 2'd2 || bus1.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_unload: idx %0d vld %b, need 2 1",
                     bus1.out_idx, bus1.out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus1.out_valid, bus0.out_valid, bus1.out_idx, bus1.out_last,
             bus1.out_re, bus0.out_re} !== {1'b0, 1'b0, 2'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_unload: vld %b/%b idx %0d last %b re %0d/%0d, need 0/0 0 0 0/0",
                     bus1.out_valid, bus0.out_valid, bus1.out_idx,
                     bus1.out_last, bus1.out_re, bus0.out_re);
        end
        test_impulse();
    endtask

    task automatic test_back_to_back();
        int xr [4];
        int xi [4];
        int sr;
        int si;
        int m;
        int e1r;
        int e1i;
        int e0r;
        int e0i;
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 4; k++) begin
                xr[k] = int'($signed(16'($urandom)));
                xi[k] = int'($signed(16'($urandom)));
            end
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(xr[((i & 1) << 1) | (i >> 1)], xi[((i & 1) << 1) | (i >> 1)]);
            end
            for (int n = 0; n < 4; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pop(n);
            end
            for (int n = 0; n < 4; n++) begin
                sr = 0;
                si = 0;
                for (int k = 0; k < 4; k++) begin
                    m = (k * n) % 4;
                    case (m)
                        0: begin sr += xr[k]; si += xi[k]; end
                        1: begin sr -= xi[k]; si += xr[k]; end
                        2: begin sr -= xr[k]; si -= xi[k]; end
                        default: begin sr += xi[k]; si -= xr[k]; end
                    endcase
                end
                e1r = (sr + 2) >>> 2;
                e1i = (si + 2) >>> 2;
                e0r = (sr > 32767) ? 32767 : ((sr < -32768) ? -32768 : sr);
                e0i = (si > 32767) ? 32767 : ((si < -32768) ? -32768 : si);
                checks++;
                if (g1_re[n] !== 16'(e1r) || g1_im[n] !== 16'(e1i) ||
                    g0_re[n] !== 16'(e0r) || g0_im[n] !== 16'(e0i) ||
                    gi[n] !== 2'(n)) begin
                    errors++;
                    $display("FAIL b2b f=%0d n=%0d: got (%0d,%0d)/(%0d,%0d) idx %0d, need (%0d,%0d)/(%0d,%0d) idx %0d",
                             f, n, g1_re[n], g1_im[n], g0_re[n], g0_im[n],
                             gi[n], e1r, e1i, e0r, e0i, n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_impulse();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
